// File: rtl/wide_add_sequencer_if.sv
// Handshake/bus bundle for wide_add_sequencer.
//
// Both handshakes use the same rule: a transfer happens on a rising clock
// edge where valid and ready are both high. The producer keeps valid high
// with stable payload until that edge. Neither ready depends
// combinationally on the matching valid.
//
// Signals (W = 32*NUM_CHUNKS):
//   in_valid/in_ready : operand request handshake
//   a, b, sub         : operands and operation select (1 = a-b)
//   out_valid/out_ready : result handshake
//   result, carry_out, overflow, zero : result and flags
//   busy              : operation in progress (RUN or DONE)
interface wide_add_sequencer_if #(
  parameter int NUM_CHUNKS = 4
);
  localparam int W = 32 * NUM_CHUNKS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         busy;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero, busy
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder/subtractor. Operands of NUM_CHUNKS x 32 bits are
// processed one 32-bit chunk per cycle through a single shared lookahead
// chunk adder; the inter-chunk carry lives in a register.
//
// Ports:
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset
//   bus     : wide_add_sequencer_if.slave (handshakes, operands, result)
//   state_o : current FSM state (debug)
module wide_add_sequencer #(
  parameter int NUM_CHUNKS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wide_add_sequencer_if.slave  bus,
  output logic [1:0]           state_o
);
  localparam int IDX_W = $clog2(NUM_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                   state_q, state_d;
  logic [NUM_CHUNKS-1:0][31:0]  op_a_q, op_a_d;
  logic [NUM_CHUNKS-1:0][31:0]  op_b_q, op_b_d;
  logic [NUM_CHUNKS-1:0][31:0]  result_q, result_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         carry_q, carry_d;
  logic                         zacc_q, zacc_d;
  logic                         cout_q, cout_d;
  logic                         ov_q, ov_d;
  logic                         zero_q, zero_d;

  // Shared 32-bit chunk adder: 4-bit group propagate/generate, then an
  // 8-group carry chain seeded by carry_q.
  logic [31:0] ca, cb, cs;
  logic [31:0] p_bit, g_bit;
  logic [7:0]  gp, gg, gc;
  logic        cc;

  always_comb begin
    logic gacc;
    logic bc;
    ca    = op_a_q[idx_q];
    cb    = op_b_q[idx_q];
    p_bit = ca ^ cb;
    g_bit = ca & cb;
    gp    = '0;
    gg    = '0;
    gc    = '0;
    cs    = '0;
    gacc  = 1'b0;
    bc    = 1'b0;
    for (int gi = 0; gi < 8; gi++) begin
      gp[gi] = &p_bit[gi*4 +: 4];
      gacc   = 1'b0;
      for (int j = 0; j < 4; j++) begin
        gacc = g_bit[gi*4+j] | (p_bit[gi*4+j] & gacc);
      end
      gg[gi] = gacc;
    end
    gc[0] = gg[0] | (gp[0] & carry_q);
    for (int gi = 1; gi < 8; gi++) begin
      gc[gi] = gg[gi] | (gp[gi] & gc[gi-1]);
    end
    // Sum bits ripple only inside a group, from that group's carry-in.
    for (int gi = 0; gi < 8; gi++) begin
      bc = (gi == 0) ? carry_q : gc[gi-1];
      for (int j = 0; j < 4; j++) begin
        cs[gi*4+j] = p_bit[gi*4+j] ^ bc;
        bc         = g_bit[gi*4+j] | (p_bit[gi*4+j] & bc);
      end
    end
    cc = gc[7];
  end

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    zacc_d   = zacc_q;
    cout_d   = cout_q;
    ov_d     = ov_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_a_d  = bus.a;
          // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
          op_b_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          idx_d   = '0;
          zacc_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        result_d[idx_q] = cs;
        carry_d         = cc;
        zacc_d          = zacc_q & (cs == 32'd0);
        idx_d           = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = cc;
          zero_d  = zacc_q & (cs == 32'd0);
          // op_b already holds the inverted operand for sub, so one rule
          // covers both add and subtract.
          ov_d    = (op_a_q[NUM_CHUNKS-1][31] == op_b_q[NUM_CHUNKS-1][31]) &
                    (cs[31] != op_a_q[NUM_CHUNKS-1][31]);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      cout_q   <= 1'b0;
      ov_q     <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
      cout_q   <= cout_d;
      ov_q     <= ov_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_RUN) | (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ov_q;
  assign bus.zero      = zero_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer (NUM_CHUNKS = 4). Expected results come from
// a full-width arithmetic model pushed at accept and popped at out_valid.
module tb_wide_add_sequencer;
  localparam int NC = 4;
  localparam int W  = 32 * NC;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  wide_add_sequencer_if #(.NUM_CHUNKS(NC)) bus ();

  wide_add_sequencer #(.NUM_CHUNKS(NC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W+2:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [255:0] obs,
                           input logic [255:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Packed {carry_out, overflow, zero, result}.
  function automatic logic [W+2:0] model(input logic [W-1:0] a_v,
                                         input logic [W-1:0] b_v,
                                         input logic s_v);
    logic [W:0] full;
    logic       ov;
    if (s_v) begin
      full = {1'b0, a_v} - {1'b0, b_v};
      // carry out of a + ~b + 1 is the inverse of the borrow
      full[W] = ~full[W];
      ov = (a_v[W-1] != b_v[W-1]) && (full[W-1] != a_v[W-1]);
    end else begin
      full = {1'b0, a_v} + {1'b0, b_v};
      ov = (a_v[W-1] == b_v[W-1]) && (full[W-1] != a_v[W-1]);
    end
    return {full[W], ov, (full[W-1:0] == '0), full[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < NC; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [W+2:0] observed();
    return {bus.carry_out, bus.overflow, bus.zero, bus.result};
  endfunction

  // ---------------- driver ----------------
  // Issues one request, checks latency and the scoreboard entry, then
  // optionally holds out_ready low for 'hold' cycles while poking in_valid.
  task automatic do_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                       input logic s_v, input int hold,
                       output logic [W+2:0] obs);
    int           cnt;
    bit           got;
    logic [W+2:0] exp_v;
    @(negedge clk);
    check_val("in_ready_idle", bus.in_ready, 1);
    bus.out_ready = (hold == 0);
    bus.a         = a_v;
    bus.b         = b_v;
    bus.sub       = s_v;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(a_v, b_v, s_v));
    #1;
    bus.in_valid = 1'b0;
    bus.a        = ~a_v;
    bus.b        = ~b_v;
    bus.sub      = ~s_v;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 64) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      got = bus.out_valid;
    end
    check_val("latency", cnt, NC);
    obs = observed();
    if (!got) return;
    if (exp_q.size() == 0) begin
      check_val("queue_underflow", 1, 0);
      return;
    end
    exp_v = exp_q.pop_front();
    check_val("result_flags", obs, exp_v);
    check_val("busy_done", bus.busy, 1);
    if (hold == 0) begin
      @(posedge clk);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = rand_w();
      bus.b        = rand_w();
      @(posedge clk);
      @(negedge clk);
      check_val("bp_out_valid", bus.out_valid, 1);
      check_val("bp_in_ready", bus.in_ready, 0);
      check_val("bp_busy", bus.busy, 1);
      check_val("bp_stable", observed(), obs);
    end
    // Release with in_valid still high: the DONE->IDLE edge must not accept.
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("release_in_ready", bus.in_ready, 1);
    check_val("release_out_valid", bus.out_valid, 0);
    check_val("release_state", dbg_state, 2'd0);
    bus.in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [W+2:0] obs;
  logic [W-1:0] ones;
  int           highs;

  initial begin
    ones          = '1;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", bus.in_ready, 1);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_outputs", observed(), 0);
    check_val("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;

    // Ripple across every chunk boundary.
    do_op(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 0, obs);
    check_val("ripple", obs, {3'b000, 128'h0000_0001_0000_0000_0000_0000_0000_0000});
    // Subtract equal.
    do_op(128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF,
          128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 1'b1, 0, obs);
    check_val("sub_equal", obs, {3'b101, 128'd0});
    // Signed overflow and unsigned wrap.
    do_op({1'b0, ones[W-2:0]}, 128'd1, 1'b0, 0, obs);
    check_val("signed_ovf", obs, {3'b010, 1'b1, {(W-1){1'b0}}});
    do_op(ones, ones, 1'b0, 0, obs);
    check_val("all_ones_add", obs, {3'b100, ones[W-1:1], 1'b0});
    // Borrow.
    do_op(128'd0, 128'd1, 1'b1, 0, obs);
    check_val("borrow", obs, {3'b000, ones});

    // Random operations with occasional short backpressure.
    for (int n = 0; n < 16; n++) begin
      do_op(rand_w(), rand_w(), 1'($urandom_range(0, 1)),
            (n % 5 == 4) ? int'($urandom_range(1, 3)) : 0, obs);
    end

    // Long backpressure with ignored requests in the window.
    do_op(rand_w(), rand_w(), 1'b1, 10, obs);

    // Reset in the middle of RUN (after idx reaches 2).
    @(negedge clk);
    bus.a        = 128'd77;
    bus.b        = 128'd11;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(128'd77, 128'd11, 1'b0));
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_val("pre_rst_state", dbg_state, 2'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_val("midrst_in_ready", bus.in_ready, 1);
    check_val("midrst_out_valid", bus.out_valid, 0);
    check_val("midrst_busy", bus.busy, 0);
    check_val("midrst_outputs", observed(), 0);
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) highs++;
    end
    check_val("midrst_no_valid", highs, 0);
    do_op(128'd5, 128'd3, 1'b1, 0, obs);
    check_val("after_rst_sub", obs, {3'b100, 128'd2});

    check_val("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
